fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer: owns the architectural fetch PC that drives the fetch unit.
//  Selects the next PC from reset vector, EX-stage redirect, debug halt, pipeline hold,
//  bus wait, predicted-taken target or PC+4, and generates fetch-valid/flush for if_id.
//  Keeps saturating fetch and redirect counters for performance monitoring.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value presented after reset release
//  CNT_W      32             width of performance counters
// PORTS
//  clk             in   1     core clock
//  rst             in   1     asynchronous reset, active low
//  jump_flag_i     in   1     EX redirect (mispredict/jalr correction) valid
//  jump_addr_i     in   32    EX redirect target
//  hold_i          in   1     pipeline stall from ctrl: freeze PC
//  halt_req_i      in   1     debug halt request (level)
//  rib_gnt_i       in   1     instruction bus grant/ready for current pc_o
//  prdt_taken_i    in   1     fetch-unit prediction: branch/jump taken
//  prdt_addr_i     in   32    fetch-unit predicted target
//  pc_o            out  32    fetch PC to fetch unit (registered)
//  inst_valid_o    out  1     fetched instruction at pc_o is valid for if_id
//  flush_o         out  1     kill wrong-path instruction in if_id
//  halted_o        out  1     core fetch halted (debug)
//  fetch_cnt_o     out  CNT_W valid fetches retired into if_id, saturating
//  redirect_cnt_o  out  CNT_W accepted EX redirects, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): pc_o=RESET_PC, state=BOOT, all other outputs/counters 0.
//  - States: BOOT, RUN, WAIT_BUS, HALT. pc_o/state/counters registered; valid/flush comb.
//  - BOOT: inst_valid_o=0; next cycle RUN, pc_o unchanged. Inputs ignored.
//  - Next-PC priority in RUN/WAIT_BUS/HALT (highest first):
//    1 jump_flag_i: pc<={jump_addr_i[31:2],2'b00}; flush_o=1; redirect_cnt++; state unchanged
//      except WAIT_BUS/HALT keep their state.
//    2 halt_req_i: pc hold; ->HALT.
//    3 hold_i: pc hold; state unchanged.
//    4 !rib_gnt_i: pc hold; ->WAIT_BUS.
//    5 prdt_taken_i: pc<={prdt_addr_i[31:2],2'b00}.
//    6 else pc<=pc_o+4, wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  - WAIT_BUS: ->RUN when rib_gnt_i=1 (and no halt); pc advances per rules 5/6 that cycle.
//  - HALT: halted_o=1 (registered, 1 cycle after entry); ->RUN one cycle after halt_req_i
//    drops; pc resumes from held (or redirected) value.
//  - inst_valid_o = (state==RUN|WAIT_BUS) & rib_gnt_i & !jump_flag_i & !halt_req_i & !hold_i.
//  - flush_o = jump_flag_i & (state!=BOOT); same cycle as redirect, 0-cycle latency.
//  - fetch_cnt_o increments when inst_valid_o=1; both counters stick at all-ones.
//  - Redirect latency: jump_flag_i in cycle N -> pc_o=target in N+1.
//  - Simultaneous jump_flag_i & prdt_taken_i: jump wins, prediction discarded.
//  - Reset mid-operation: immediate return to reset values, counters cleared.
// STRUCTURE
//  - Bus widths (InstAddrBus, InstBus), RstEnable polarity, NOP constant from defines.vh;
//    add FETCH_ST_* state encodings (2-bit) and RESET_PC default there.
//  - One sub-module natural: sat_counter (CNT_W param, en, clr) instantiated twice.
//  - Single always block for state/pc; separate comb next-PC mux.
// TESTING
//  - Reset release, gnt=1, no events -> pc 0,0,4,8,C; valid low in BOOT, high after.
//  - pc=0x100, prdt_taken_i=1 addr 0x200 -> next pc 0x200; no flush; fetch_cnt+1.
//  - pc=0x200, jump_flag_i=1 addr 0x303 & prdt_taken_i=1 -> pc 0x300, flush_o=1 same cycle,
//    inst_valid_o=0, redirect_cnt=1.
//  - rib_gnt_i low 3 cycles at pc 0x40 -> WAIT_BUS, pc holds 0x40, valid 0; gnt high -> 0x44.
//  - halt_req_i 4 cycles at pc 0x80 -> halted_o=1, pc 0x80; jump to 0x500 while halted ->
//    pc 0x500; release -> resume fetch 0x500, 0x504.
//  - pc forced 0xFFFF_FFFC, run -> wraps 0x0; counter preloaded all-ones stays all-ones;
//    rst asserted mid-run -> pc=RESET_PC, counters 0 asynchronously.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

   localparam int          INST_ADDR_W  = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_ST_BOOT     = 2'd0,
      FETCH_ST_RUN      = 2'd1,
      FETCH_ST_WAIT_BUS = 2'd2,
      FETCH_ST_HALT     = 2'd3
   } fetch_state_e;

   // Fetch targets are always word aligned; the low two bits are dropped.
   function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] addr);
      return {addr[INST_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-sequencer signal bundle: control inputs from EX/ctrl/debug/bus and the fetch outputs.
// Handshake: rib_gnt_i is the ready for the address on pc_o; a fetch completes in a cycle where
// inst_valid_o=1 (which implies rib_gnt_i=1), and pc_o only advances on such a completed fetch.
interface fetch_ctrl_if #(parameter int CNT_W = 32);

   logic             jump_flag_i;
   logic [31:0]      jump_addr_i;
   logic             hold_i;
   logic             halt_req_i;
   logic             rib_gnt_i;
   logic             prdt_taken_i;
   logic [31:0]      prdt_addr_i;
   logic [31:0]      pc_o;
   logic             inst_valid_o;
   logic             flush_o;
   logic             halted_o;
   logic [CNT_W-1:0] fetch_cnt_o;
   logic [CNT_W-1:0] redirect_cnt_o;

   modport master (
      output jump_flag_i, jump_addr_i, hold_i, halt_req_i, rib_gnt_i, prdt_taken_i, prdt_addr_i,
      input  pc_o, inst_valid_o, flush_o, halted_o, fetch_cnt_o, redirect_cnt_o
   );

   modport slave (
      input  jump_flag_i, jump_addr_i, hold_i, halt_req_i, rib_gnt_i, prdt_taken_i, prdt_addr_i,
      output pc_o, inst_valid_o, flush_o, halted_o, fetch_cnt_o, redirect_cnt_o
   );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, asynchronous active-low reset.
module fetch_ctrl_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, chooses the next PC and raises valid/flush
// toward if_id, with saturating fetch and redirect counters.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          CNT_W    = 32
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.slave  bus,
   output fetch_state_e state_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         inst_valid;
   logic         flush;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_valid = 1'b0;
      flush      = 1'b0;

      if (state_q != FETCH_ST_BOOT) begin
         flush      = bus.jump_flag_i;
         inst_valid = ((state_q == FETCH_ST_RUN) || (state_q == FETCH_ST_WAIT_BUS)) &&
                      bus.rib_gnt_i && !bus.jump_flag_i && !bus.halt_req_i && !bus.hold_i;
      end

      case (state_q)
         FETCH_ST_BOOT: begin
            state_d = FETCH_ST_RUN;
         end
         // A redirect while halted only moves the PC; fetch resumes from it after release.
         FETCH_ST_HALT: begin
            if (bus.jump_flag_i) begin
               pc_d = align_pc(bus.jump_addr_i);
            end else if (!bus.halt_req_i) begin
               state_d = FETCH_ST_RUN;
            end
         end
         default: begin
            if (bus.jump_flag_i) begin
               pc_d = align_pc(bus.jump_addr_i);
            end else if (bus.halt_req_i) begin
               state_d = FETCH_ST_HALT;
            end else if (bus.hold_i) begin
               state_d = state_q;
            end else if (!bus.rib_gnt_i) begin
               state_d = FETCH_ST_WAIT_BUS;
            end else begin
               state_d = FETCH_ST_RUN;
               pc_d    = bus.prdt_taken_i ? align_pc(bus.prdt_addr_i) : pc_q + 32'd4;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH_ST_BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_ctrl_sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
      .clk     (clk),
      .rst     (rst),
      .en      (inst_valid),
      .clr     (1'b0),
      .count_o (bus.fetch_cnt_o)
   );

   fetch_ctrl_sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
      .clk     (clk),
      .rst     (rst),
      .en      (flush),
      .clr     (1'b0),
      .count_o (bus.redirect_cnt_o)
   );

   assign bus.pc_o         = pc_q;
   assign bus.inst_valid_o = inst_valid;
   assign bus.flush_o      = flush;
   assign bus.halted_o     = (state_q == FETCH_ST_HALT);
   assign state_o          = state_q;

endmodule
